// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial word shifter with valid/ready input. Optional even-parity bit per word under PARITY_EN.
// First bit one cycle after acceptance. in_ready opens on the final bit cycle, so back-to-back words stream with no gap.
module serial_tx_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             data_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
  logic par;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // The "output end" of sreg is the MSB or LSB depending on bit order.
  assign first_bit    = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign next_bit     = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

`ifdef PARITY_EN
  assign in_ready = (state == IDLE) || ((state == PAR) && !flush);
`else
  assign in_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST) && !flush);
`endif

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      data_out  <= 1'b0;
      bit_valid <= 1'b0;
`ifdef PARITY_EN
      par       <= 1'b0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      data_out  <= 1'b0;
      bit_valid <= 1'b0;
    end else if (accept) begin
      // Covers both the idle start and the zero-gap reload on the final bit.
      state     <= SHIFT;
      sreg      <= in_data;
      cnt       <= '0;
      data_out  <= first_bit;
      bit_valid <= 1'b1;
`ifdef PARITY_EN
      par       <= ^in_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != LAST) begin
            sreg     <= sreg_shifted;
            cnt      <= cnt + CW'(1);
            data_out <= next_bit;
          end else begin
`ifdef PARITY_EN
            state    <= PAR;
            data_out <= par;
`else
            state     <= IDLE;
            cnt       <= '0;
            data_out  <= 1'b0;
            bit_valid <= 1'b0;
`endif
          end
        end
`ifdef PARITY_EN
        PAR: begin
          state     <= IDLE;
          cnt       <= '0;
          data_out  <= 1'b0;
          bit_valid <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench for serial_tx_shifter: one MSB-first and one LSB-first instance on a shared clock and reset.
module tb_serial_tx_shifter;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a_in_data = '0, b_in_data = '0;
  logic         a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic         a_flush = 1'b0, b_flush = 1'b0;
  logic         a_in_ready, b_in_ready;
  logic         a_data_out, b_data_out;
  logic         a_bit_valid, b_bit_valid;
  logic         a_busy, b_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .flush(a_flush), .data_out(a_data_out),
    .bit_valid(a_bit_valid), .busy(a_busy)
  );

  serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush), .data_out(b_data_out),
    .bit_valid(b_bit_valid), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial bit i of word w; index W is the even-parity bit.
  function automatic logic ebit(input logic [W-1:0] w, input int i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic chk_a_idle(input string tag);
    chk({tag, "_do"}, a_data_out, 1'b0);
    chk({tag, "_bv"}, a_bit_valid, 1'b0);
    chk({tag, "_busy"}, a_busy, 1'b0);
  endtask

  task automatic chk_a_bit(input string tag, input logic [W-1:0] w, input int i);
    chk({tag, "_do"}, a_data_out, ebit(w, i, 1'b1));
    chk({tag, "_bv"}, a_bit_valid, 1'b1);
    chk({tag, "_busy"}, a_busy, 1'b1);
  endtask

  initial begin
    // Reset held three cycles, then released with nothing offered.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_a_idle("rst_hold");
      chk("rst_hold_rdy", a_in_ready, 1'b1);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk_a_idle("rst_rel");
    chk("rst_rel_rdy", a_in_ready, 1'b1);
    chk("rst_rel_b_bv", b_bit_valid, 1'b0);
    @(negedge clk);

    // Single word 8'hB0, MSB first.
    a_in_data = 8'hB0; a_in_valid = 1'b1;
    #1 chk("b0_acc_rdy", a_in_ready, 1'b1);
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1 chk_a_bit("b0_bit", 8'hB0, i);
      @(negedge clk);
    end
    #1 chk_a_idle("b0_end");

    // Back-to-back 8'hA5 then 8'h3C with in_valid held high.
    a_in_data = 8'hA5; a_in_valid = 1'b1;
    #1 chk("a5_acc_rdy", a_in_ready, 1'b1);
    @(negedge clk);
    a_in_data = 8'h3C;
    for (int i = 0; i < NB; i++) begin
      #1 chk_a_bit("a5_bit", 8'hA5, i);
      chk("a5_rdy", a_in_ready, (i == NB - 1));
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1 chk_a_bit("3c_bit", 8'h3C, i);
      @(negedge clk);
    end
    #1 chk_a_idle("3c_end");

    // LSB first 8'h01; a second word (8'hC3) is offered from bit 3 and must wait for the last bit.
    b_in_data = 8'h01; b_in_valid = 1'b1;
    #1 chk("lsb_acc_rdy", b_in_ready, 1'b1);
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == 2) begin
        b_in_data = 8'hC3; b_in_valid = 1'b1;
      end
      #1 chk("lsb01_do", b_data_out, ebit(8'h01, i, 1'b0));
      chk("lsb01_bv", b_bit_valid, 1'b1);
      chk("lsb01_rdy", b_in_ready, (i == NB - 1));
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1 chk("lsbc3_do", b_data_out, ebit(8'hC3, i, 1'b0));
      chk("lsbc3_bv", b_bit_valid, 1'b1);
      @(negedge clk);
    end
    #1 chk("lsb_end_bv", b_bit_valid, 1'b0);
    chk("lsb_end_busy", b_busy, 1'b0);

    // Asynchronous reset pulse between edges during bit 3 of 8'hFF.
    a_in_data = 8'hFF; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_a_bit("ff_bit", 8'hFF, i);
      if (i < 2) @(negedge clk);
    end
    #1 reset = 1'b1;
    #1 chk_a_idle("arst_mid");
    chk("arst_mid_rdy", a_in_ready, 1'b1);
    #1 reset = 1'b0;
    @(negedge clk);
    #1 chk_a_idle("arst_after");

    // Next word after reset starts from its first bit.
    a_in_data = 8'h80; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1 chk_a_bit("w80_bit", 8'h80, i);
      @(negedge clk);
    end
    #1 chk_a_idle("w80_end");

    // Flush at bit 5 returns to idle on the next edge.
    a_in_data = 8'hFF; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk_a_bit("fl5_bit", 8'hFF, i);
      if (i < 4) @(negedge clk);
    end
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    #1 chk_a_idle("fl5_after");

    // Flush on the final bit blocks a pending accept; the word is then sent whole.
    a_in_data = 8'h5A; a_in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NB - 1; i++) begin
      #1 chk_a_bit("fll_bit", 8'h5A, i);
      @(negedge clk);
    end
    a_flush = 1'b1;
    #1 chk("fll_rdy_blocked", a_in_ready, 1'b0);
    @(negedge clk);
    a_flush = 1'b0;
    #1 chk_a_idle("fll_after");
    chk("fll_idle_rdy", a_in_ready, 1'b1);
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1 chk_a_bit("fll_resend", 8'h5A, i);
      @(negedge clk);
    end
    #1 chk_a_idle("fll_end");

`ifdef PARITY_EN
    // Parity words back to back: 8'h07 -> parity 1, 8'h03 -> parity 0.
    a_in_data = 8'h07; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_data = 8'h03;
    for (int i = 0; i < NB; i++) begin
      #1 chk_a_bit("p07_bit", 8'h07, i);
      chk("p07_rdy", a_in_ready, (i == NB - 1));
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1 chk_a_bit("p03_bit", 8'h03, i);
      @(negedge clk);
    end
    #1 chk_a_idle("par_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
